// File: rtl/thread_scheduler.sv
// thread_scheduler: barrel-thread issue controller.
//
// Rotates a thread ID through NUM_THREADS slots (one slot per cycle while
// running), marks each slot live or bubble from the per-thread active mask,
// and carries {valid, tid} down a PIPE_DEPTH-1 stage delay line so writeback
// receives a matching tag. A small IDLE/RUN/DRAIN FSM sequences start, halt
// and drain for the loader/debug host.
//
// Optional build macro: THREAD_SCHED_PERF_CNT_EN adds perf_issued/perf_bubbles.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   start               pulse, begin issuing (IDLE only; wins over halt_req)
//   halt_req            pulse, stop issuing and drain (RUN only)
//   en_wr/en_wr_tid/en_wr_val  single-bit write to active_mask
//   issue_valid/issue_tid      current issue slot
//   wb_valid/wb_tid            issue slot delayed PIPE_DEPTH-1 cycles
//   active_mask         current enable mask
//   busy                state != IDLE
//   drained             one-cycle pulse when the last in-flight slot reaches wb
//   perf_issued/perf_bubbles   (optional) saturating slot counters
module thread_scheduler #(
  parameter int NUM_THREADS = 32,
  parameter int PIPE_DEPTH  = 19,
  parameter logic [NUM_THREADS-1:0] INIT_MASK = {NUM_THREADS{1'b1}},
  localparam int TID_W = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   en_wr,
  input  logic [TID_W-1:0]       en_wr_tid,
  input  logic                   en_wr_val,
  output logic                   issue_valid,
  output logic [TID_W-1:0]       issue_tid,
  output logic                   wb_valid,
  output logic [TID_W-1:0]       wb_tid,
  output logic [NUM_THREADS-1:0] active_mask,
  output logic                   busy,
  output logic                   drained
`ifdef THREAD_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]            perf_issued,
  output logic [31:0]            perf_bubbles
`endif
);

  localparam int CNT_W    = $clog2(PIPE_DEPTH + 1);
  localparam int LAST_TID = NUM_THREADS - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              drain_cnt;
  logic                          drain_done;
  logic                          slot_gen;
  logic [TID_W-1:0]              slot_tid;
  logic [PIPE_DEPTH-2:0]         vld_pipe;
  logic [PIPE_DEPTH-2:0][TID_W-1:0] tid_pipe;

  // drain_cnt is 1 in the first non-issue cycle, so it hits PIPE_DEPTH-1 in
  // the cycle the last issued slot sits on wb_*.
  assign drain_done = (drain_cnt == CNT_W'(PIPE_DEPTH - 1));

  // Next state plus the slot generated at this edge. The wrap uses an
  // explicit compare so non-power-of-two thread counts rotate correctly.
  always_comb begin
    state_d  = state_q;
    slot_gen = 1'b0;
    slot_tid = issue_tid;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          slot_gen = 1'b1;
          slot_tid = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d = DRAIN;
        end else begin
          slot_gen = 1'b1;
          slot_tid = (issue_tid == TID_W'(LAST_TID)) ? '0 : issue_tid + TID_W'(1);
        end
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_valid <= 1'b0;
      issue_tid   <= '0;
      drain_cnt   <= CNT_W'(1);
      drained     <= 1'b0;
      active_mask <= INIT_MASK;
      vld_pipe    <= '0;
      tid_pipe    <= '0;
    end else begin
      state_q     <= state_d;
      // Mask read here sees the pre-edge value, so a same-edge write only
      // affects that thread's next slot.
      issue_valid <= slot_gen & active_mask[slot_tid];
      issue_tid   <= slot_tid;
      drain_cnt   <= (state_q == DRAIN) ? drain_cnt + CNT_W'(1) : CNT_W'(1);
      drained     <= (state_q == DRAIN) && (drain_cnt == CNT_W'(PIPE_DEPTH - 2));
      if (en_wr && (int'(en_wr_tid) < NUM_THREADS))
        active_mask[en_wr_tid] <= en_wr_val;
      vld_pipe    <= {vld_pipe[PIPE_DEPTH-3:0], issue_valid};
      tid_pipe    <= {tid_pipe[PIPE_DEPTH-3:0], issue_tid};
    end
  end

  assign wb_valid = vld_pipe[PIPE_DEPTH-2];
  assign wb_tid   = tid_pipe[PIPE_DEPTH-2];
  assign busy     = (state_q != IDLE);

`ifdef THREAD_SCHED_PERF_CNT_EN
  // Counts the slots presented while in RUN; frozen outside RUN.
  always_ff @(posedge clk) begin
    if (reset || (state_q == IDLE && start)) begin
      perf_issued  <= '0;
      perf_bubbles <= '0;
    end else if (state_q == RUN) begin
      if (issue_valid) begin
        if (perf_issued != 32'hFFFF_FFFF) perf_issued <= perf_issued + 32'd1;
      end else begin
        if (perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler: a 32-thread/19-stage instance and a
// 6-thread/4-stage instance share one stimulus stream. A slot-level model
// (state flag, rotating tid, per-cycle issue history) predicts every output
// each cycle; literal checks pin the model at key points of the directed run.
module tb_thread_scheduler;
  localparam int N0 = 32, D0 = 19;
  localparam int N1 = 6,  D1 = 4;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic reset, start, halt_req, en_wr, en_wr_val;
  logic [4:0] wtid0;
  logic [2:0] wtid1;

  logic iv0, wbv0, busy0, dr0;
  logic [4:0] it0, wbt0;
  logic [31:0] am0;
  logic iv1, wbv1, busy1, dr1;
  logic [2:0] it1, wbt1;
  logic [5:0] am1;
`ifdef THREAD_SCHED_PERF_CNT_EN
  logic [31:0] pi0, pb0, pi1, pb1;
`endif

  thread_scheduler #(.NUM_THREADS(N0), .PIPE_DEPTH(D0)) u_big (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .en_wr(en_wr), .en_wr_tid(wtid0), .en_wr_val(en_wr_val),
    .issue_valid(iv0), .issue_tid(it0), .wb_valid(wbv0), .wb_tid(wbt0),
    .active_mask(am0), .busy(busy0), .drained(dr0)
`ifdef THREAD_SCHED_PERF_CNT_EN
    , .perf_issued(pi0), .perf_bubbles(pb0)
`endif
  );

  thread_scheduler #(.NUM_THREADS(N1), .PIPE_DEPTH(D1)) u_small (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .en_wr(en_wr), .en_wr_tid(wtid1), .en_wr_val(en_wr_val),
    .issue_valid(iv1), .issue_tid(it1), .wb_valid(wbv1), .wb_tid(wbt1),
    .active_mask(am1), .busy(busy1), .drained(dr1)
`ifdef THREAD_SCHED_PERF_CNT_EN
    , .perf_issued(pi1), .perf_bubbles(pb1)
`endif
  );

  always #5 clk = ~clk;

  int cmp_n = 0, err_n = 0;
  int cyc = 0;

  // Model state: st 0=idle 1=run 2=drain
  int m_st[2], m_tid[2], m_v[2], m_dend[2], m_dr[2], m_rc[2];
  longint m_pi[2], m_pb[2];
  logic [31:0] m_mask[2];
  int hv[2][HMAX];
  int ht[2][HMAX];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic mupd(input int i, input int n, input int d, input int wt);
    int ns, ntid, nv;
    bit gen;
    if (reset) begin
      m_st[i] = 0; m_tid[i] = 0; m_v[i] = 0; m_dr[i] = 0; m_rc[i] = cyc;
      m_mask[i] = 32'((64'd1 << n) - 64'd1);
      m_pi[i] = 0; m_pb[i] = 0;
    end else begin
      ns = m_st[i]; gen = 1'b0; ntid = m_tid[i];
      case (m_st[i])
        0: if (start) begin
             ns = 1; gen = 1'b1; ntid = 0; m_pi[i] = 0; m_pb[i] = 0;
           end
        1: begin
             if (m_v[i] != 0) m_pi[i] = (m_pi[i] < 64'hFFFF_FFFF) ? m_pi[i] + 1 : m_pi[i];
             else             m_pb[i] = (m_pb[i] < 64'hFFFF_FFFF) ? m_pb[i] + 1 : m_pb[i];
             if (halt_req) begin
               ns = 2; m_dend[i] = cyc + d - 2;
             end else begin
               gen = 1'b1; ntid = (m_tid[i] + 1) % n;
             end
           end
        default: if (cyc - 1 == m_dend[i]) ns = 0;
      endcase
      nv = gen ? int'(m_mask[i][ntid]) : 0;
      if (en_wr && wt < n) m_mask[i][wt] = en_wr_val;
      m_dr[i] = (ns == 2 && cyc == m_dend[i]) ? 1 : 0;
      m_st[i] = ns; m_tid[i] = ntid; m_v[i] = nv;
    end
    hv[i][cyc] = m_v[i];
    ht[i][cyc] = m_tid[i];
  endtask

  task automatic mcheck();
    int k, ev, et;
    k = cyc - (D0 - 1);
    ev = (k >= m_rc[0]) ? hv[0][k] : 0;
    et = (k >= m_rc[0]) ? ht[0][k] : 0;
    chk("big.issue_valid", 32'(iv0), 32'(m_v[0]));
    chk("big.issue_tid",   32'(it0), 32'(m_tid[0]));
    chk("big.wb_valid",    32'(wbv0), 32'(ev));
    chk("big.wb_tid",      32'(wbt0), 32'(et));
    chk("big.active_mask", am0, m_mask[0]);
    chk("big.busy",        32'(busy0), 32'(m_st[0] != 0));
    chk("big.drained",     32'(dr0), 32'(m_dr[0]));
    k = cyc - (D1 - 1);
    ev = (k >= m_rc[1]) ? hv[1][k] : 0;
    et = (k >= m_rc[1]) ? ht[1][k] : 0;
    chk("small.issue_valid", 32'(iv1), 32'(m_v[1]));
    chk("small.issue_tid",   32'(it1), 32'(m_tid[1]));
    chk("small.wb_valid",    32'(wbv1), 32'(ev));
    chk("small.wb_tid",      32'(wbt1), 32'(et));
    chk("small.active_mask", 32'(am1), m_mask[1]);
    chk("small.busy",        32'(busy1), 32'(m_st[1] != 0));
    chk("small.drained",     32'(dr1), 32'(m_dr[1]));
`ifdef THREAD_SCHED_PERF_CNT_EN
    chk("big.perf_issued",    pi0, 32'(m_pi[0]));
    chk("big.perf_bubbles",   pb0, 32'(m_pb[0]));
    chk("small.perf_issued",  pi1, 32'(m_pi[1]));
    chk("small.perf_bubbles", pb1, 32'(m_pb[1]));
`endif
  endtask

  task automatic step(input bit r, input bit s, input bit h, input bit w,
                      input int wt0, input int wt1, input bit wv);
    @(negedge clk);
    reset = r; start = s; halt_req = h; en_wr = w;
    wtid0 = 5'(wt0); wtid1 = 3'(wt1); en_wr_val = wv;
    @(posedge clk);
    cyc++;
    mupd(0, N0, D0, wt0);
    mupd(1, N1, D1, wt1);
    #1;
    mcheck();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; en_wr = 1'b0;
    wtid0 = '0; wtid1 = '0; en_wr_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_tid[i] = 0; m_v[i] = 0; m_dr[i] = 0; m_rc[i] = 0;
      m_dend[i] = 0; m_pi[i] = 0; m_pb[i] = 0; m_mask[i] = '0;
      hv[i][0] = 0; ht[i][0] = 0;
    end

    // Reset values
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("lit.rst_busy", 32'(busy0), 32'd0);
    chk("lit.rst_iv", 32'(iv0), 32'd0);
    chk("lit.rst_mask_big", am0, 32'hFFFF_FFFF);
    chk("lit.rst_mask_small", 32'(am1), 32'h3F);

    // Clear threads 3 and 7 (7 is out of range for the 6-thread instance)
    step(1'b0, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 7, 7, 1'b0);
    chk("lit.mask_clr_big", am0, 32'hFFFF_FF77);
    chk("lit.mask_clr_small", 32'(am1), 32'h37);

    // Start: cycle 1 shows tid 0
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("lit.first_tid", 32'(it0), 32'd0);
    chk("lit.first_valid", 32'(iv0), 32'd1);
    for (int k = 2; k <= 43; k++) begin
      if (k == 6) step(1'b0, 1'b0, 1'b0, 1'b1, 5, 5, 1'b0);  // tid 5 being generated
      else idle_step();
      if (k == 4) begin
        chk("lit.bubble3_tid", 32'(it0), 32'd3);
        chk("lit.bubble3_valid", 32'(iv0), 32'd0);
        chk("lit.small_bubble3", 32'(iv1), 32'd0);
      end
      if (k == 6) begin
        chk("lit.samecyc_tid", 32'(it0), 32'd5);
        chk("lit.samecyc_valid", 32'(iv0), 32'd1);
        chk("lit.small_tid5", 32'(it1), 32'd5);
      end
      if (k == 7) chk("lit.small_wrap", 32'(it1), 32'd0);
      if (k == 9) chk("lit.small_wb_lag", 32'(wbt1), 32'd5);
      if (k == 19) begin
        chk("lit.wb_first_tid", 32'(wbt0), 32'd0);
        chk("lit.wb_first_valid", 32'(wbv0), 32'd1);
      end
      if (k == 22) chk("lit.wb_bubble3", 32'(wbv0), 32'd0);
      if (k == 38) begin
        chk("lit.next5_tid", 32'(it0), 32'd5);
        chk("lit.next5_valid", 32'(iv0), 32'd0);
      end
    end
    chk("lit.pre_halt_tid", 32'(it0), 32'd10);

    // Halt with issue_tid = 10
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("lit.halt_iv", 32'(iv0), 32'd0);
    chk("lit.halt_tid_frozen", 32'(it0), 32'd10);
    for (int k = 45; k <= 62; k++) begin
      idle_step();
      if (k == 46) begin
        chk("lit.small_drained", 32'(dr1), 32'd1);
        chk("lit.small_drain_wbv", 32'(wbv1), 32'd1);
      end
      if (k == 61) begin
        chk("lit.drained", 32'(dr0), 32'd1);
        chk("lit.drain_wb_tid", 32'(wbt0), 32'd10);
        chk("lit.drain_wb_valid", 32'(wbv0), 32'd1);
        chk("lit.drain_busy", 32'(busy0), 32'd1);
      end
      if (k == 62) begin
        chk("lit.post_drain_busy", 32'(busy0), 32'd0);
        chk("lit.post_drain_pulse", 32'(dr0), 32'd0);
      end
    end

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      step(($urandom % 400) == 0, ($urandom % 16) == 0, ($urandom % 40) == 0,
           ($urandom % 4) == 0, int'($urandom % 32), int'($urandom % 8),
           ($urandom % 3) != 0);
    end

    // Reset five cycles into DRAIN
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2, 2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 10; k++) idle_step();
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) idle_step();
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("lit.rst_drain_busy", 32'(busy0), 32'd0);
    chk("lit.rst_drain_pulse", 32'(dr0), 32'd0);
    chk("lit.rst_drain_mask", am0, 32'hFFFF_FFFF);
    chk("lit.rst_drain_wbv", 32'(wbv0), 32'd0);
    for (int k = 0; k < 20; k++) idle_step();

`ifdef THREAD_SCHED_PERF_CNT_EN
    // 64 RUN cycles with threads 1 and 9 disabled
    step(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9, 9, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 63; k++) idle_step();
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("lit.perf_issued", pi0, 32'd60);
    chk("lit.perf_bubbles", pb0, 32'd4);
    for (int k = 0; k < 20; k++) idle_step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
